// File: rtl/bt_pkg.sv
// Shared types and constants for the branch target table.
package bt_pkg;

  // Sweep-then-serve controller states.
  typedef enum logic {
    S_CLEAR,
    S_RUN
  } bt_state_t;

  // Value driven on the target output whenever no valid entry is being returned.
  localparam int unsigned BT_RESET_TARGET = 0;

  // Index width for an n-entry space, never narrower than one bit.
  function automatic int unsigned bt_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bt_bank_mem.sv
// One bank of branch targets: synchronous write with a valid bit, registered
// read with write-first bypass when the write and read hit the same index.
module bt_bank_mem
  import bt_pkg::*;
#(
  parameter int unsigned D     = 10,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IW    = bt_idx_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [D-1:0]  i_wdata,
  input  logic          i_wvld,
  input  logic [IW-1:0] i_raddr,
  output logic [D-1:0]  o_rdata,
  output logic          o_rvld
);

  typedef struct packed {
    logic         vld;
    logic [D-1:0] tgt;
  } bt_entry_t;

  bt_entry_t r_mem [DEPTH];
  bt_entry_t r_rd;
  bt_entry_t w_wentry;

  assign w_wentry = '{vld: i_wvld, tgt: i_wdata};

  // Storage update; the controller only raises i_we for in-range indices.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= w_wentry;
    end
  end

  // Registered read; a same-cycle write to the read index wins.
  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr == i_raddr)) begin
      r_rd <= w_wentry;
    end else begin
      r_rd <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rd.tgt;
  assign o_rvld  = r_rd.vld;

endmodule

// File: rtl/branch_target_table.sv
// Multi-bank branch target table. After reset every entry is swept to
// invalid, then lookups return the programmed target one cycle later.
module branch_target_table
  import bt_pkg::*;
#(
  parameter int unsigned D      = 10,
  parameter int unsigned A      = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NBANKS = 2,
  localparam int unsigned BW    = bt_idx_width(NBANKS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [BW-1:0] i_bank_sel,
  input  logic [A-1:0]  i_addr,
  input  logic          i_branch,
  output logic [D-1:0]  o_target,
  output logic          o_target_valid,
  output logic          o_miss,
  input  logic          i_wr_en,
  input  logic [BW-1:0] i_wr_bank,
  input  logic [A-1:0]  i_wr_addr,
  input  logic [D-1:0]  i_wr_data,
  output logic          o_busy
);

  localparam int unsigned IW = bt_idx_width(DEPTH);

  // Bounds widened by one bit so DEPTH == 2**A and NBANKS == 2**BW still fit.
  localparam logic [A:0]  DEPTH_L  = (A+1)'(DEPTH);
  localparam logic [BW:0] NBANKS_L = (BW+1)'(NBANKS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BANK = BW'(NBANKS - 1);

  bt_state_t     r_state;
  logic [BW-1:0] r_clr_bank;
  logic [IW-1:0] r_clr_idx;
  logic          r_req;
  logic          r_inrange;
  logic [BW-1:0] r_bank;

  logic          w_clearing;
  logic          w_rd_inrange;
  logic          w_wr_inrange;
  logic [IW-1:0] w_waddr;
  logic [D-1:0]  w_wdata;
  logic [IW-1:0] w_raddr;
  logic [NBANKS-1:0] w_we;
  logic [D-1:0]  w_rd_tgt [NBANKS];
  logic [NBANKS-1:0] w_rd_vld;
  logic [D-1:0]  w_sel_tgt;
  logic          w_sel_vld;
  logic          w_hit;

  assign w_clearing   = (r_state == S_CLEAR);
  assign w_rd_inrange = ({1'b0, i_bank_sel} < NBANKS_L) && ({1'b0, i_addr} < DEPTH_L);
  assign w_wr_inrange = ({1'b0, i_wr_bank} < NBANKS_L) && ({1'b0, i_wr_addr} < DEPTH_L);

  // The sweep borrows the write port; user writes only flow once running.
  assign w_waddr = w_clearing ? r_clr_idx : i_wr_addr[IW-1:0];
  assign w_wdata = w_clearing ? D'(BT_RESET_TARGET) : i_wr_data;
  assign w_raddr = i_addr[IW-1:0];

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    assign w_we[b] = !i_reset &&
                     (w_clearing ? (r_clr_bank == BW'(b))
                                 : (i_wr_en && w_wr_inrange && (i_wr_bank == BW'(b))));

    bt_bank_mem #(
      .D     (D),
      .DEPTH (DEPTH),
      .IW    (IW)
    ) u_bank (
      .i_clk   (i_clk),
      .i_we    (w_we[b]),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_wvld  (!w_clearing),
      .i_raddr (w_raddr),
      .o_rdata (w_rd_tgt[b]),
      .o_rvld  (w_rd_vld[b])
    );
  end

  // Controller: clear sweep across every bank/index, then serve lookups.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_CLEAR;
      r_clr_bank <= '0;
      r_clr_idx  <= '0;
      r_req      <= 1'b0;
      r_inrange  <= 1'b0;
      r_bank     <= '0;
    end else begin
      unique case (r_state)
        S_CLEAR: begin
          r_req     <= 1'b0;
          r_inrange <= 1'b0;
          if (r_clr_idx == LAST_IDX) begin
            r_clr_idx <= '0;
            if (r_clr_bank == LAST_BANK) begin
              r_clr_bank <= '0;
              r_state    <= S_RUN;
            end else begin
              r_clr_bank <= r_clr_bank + 1'b1;
            end
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        S_RUN: begin
          r_req     <= i_branch;
          r_inrange <= w_rd_inrange;
          r_bank    <= i_bank_sel;
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Pick the bank addressed by the lookup captured last cycle.
  always_comb begin
    w_sel_tgt = D'(BT_RESET_TARGET);
    w_sel_vld = 1'b0;
    for (int b = 0; b < NBANKS; b++) begin
      if (r_bank == BW'(b)) begin
        w_sel_tgt = w_rd_tgt[b];
        w_sel_vld = w_rd_vld[b];
      end
    end
  end

  assign w_hit          = r_req && r_inrange && w_sel_vld;
  assign o_target       = w_hit ? w_sel_tgt : D'(BT_RESET_TARGET);
  assign o_target_valid = w_hit;
  assign o_miss         = r_req && !w_hit;
  assign o_busy         = w_clearing;

endmodule

// File: tb/tb_branch_target_table.sv
// Directed bench for branch_target_table with default parameters.
module tb_branch_target_table;

  logic       clk;
  logic       reset;
  logic [0:0] bank_sel;
  logic [7:0] addr;
  logic       branch;
  logic [9:0] target;
  logic       target_valid;
  logic       miss;
  logic       wr_en;
  logic [0:0] wr_bank;
  logic [7:0] wr_addr;
  logic [9:0] wr_data;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  branch_target_table #(
    .D      (10),
    .A      (8),
    .DEPTH  (32),
    .NBANKS (2)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_bank_sel     (bank_sel),
    .i_addr         (addr),
    .i_branch       (branch),
    .o_target       (target),
    .o_target_valid (target_valid),
    .o_miss         (miss),
    .i_wr_en        (wr_en),
    .i_wr_bank      (wr_bank),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [0:0] b, input logic [7:0] a, input logic [9:0] d);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_lookup(input logic [0:0] b, input logic [7:0] a);
    bank_sel = b; addr = a; branch = 1'b1;
    tick();
    branch = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [9:0] t, input logic v,
                            input logic m);
    check({tag, "_target"}, 32'(target), 32'(t));
    check({tag, "_valid"}, 32'(target_valid), 32'(v));
    check({tag, "_miss"}, 32'(miss), 32'(m));
  endtask

  // Counts busy cycles after reset release; optionally issues traffic mid-sweep.
  task automatic run_sweep(input string tag, input bit probe);
    int cnt;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (probe && cnt == 10) begin
        bank_sel = 0; addr = 8'd5; branch = 1'b1;
      end else if (probe && cnt == 11) begin
        branch = 1'b0;
        expect_out({tag, "_sweep_branch"}, 10'd0, 1'b0, 1'b0);
      end else if (probe && cnt == 40) begin
        wr_en = 1'b1; wr_bank = 0; wr_addr = 8'd2; wr_data = 10'd77;
      end else if (probe && cnt == 41) begin
        wr_en = 1'b0;
      end
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(cnt), 32'd64);
  endtask

  initial begin
    reset = 1'b1; bank_sel = 0; addr = 0; branch = 0;
    wr_en = 0; wr_bank = 0; wr_addr = 0; wr_data = 0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd1);
    expect_out("rst", 10'd0, 1'b0, 1'b0);
    reset = 1'b0;

    run_sweep("init", 1'b1);
    check("init_busy_low", 32'(busy), 32'd0);
    do_lookup(0, 8'd2);
    expect_out("sweep_write_ignored", 10'd0, 1'b0, 1'b1);

    // Program and read back.
    do_write(0, 8'd1, 10'd3);
    do_write(1, 8'd1, 10'd26);
    do_lookup(0, 8'd1);
    expect_out("rd_b0_i1", 10'd3, 1'b1, 1'b0);
    do_lookup(1, 8'd1);
    expect_out("rd_b1_i1", 10'd26, 1'b1, 1'b0);

    // Unprogrammed and out-of-range.
    do_lookup(0, 8'd5);
    expect_out("unprog_i5", 10'd0, 1'b0, 1'b1);
    do_lookup(0, 8'd40);
    expect_out("oor_i40", 10'd0, 1'b0, 1'b1);
    do_write(0, 8'd40, 10'd55);
    do_lookup(0, 8'd8);
    expect_out("oor_wr_alias8", 10'd0, 1'b0, 1'b1);
    do_lookup(0, 8'd1);
    expect_out("oor_wr_keep1", 10'd3, 1'b1, 1'b0);

    // Write-first bypass, and no bypass across banks.
    wr_en = 1'b1; wr_bank = 0; wr_addr = 8'd7; wr_data = 10'd99;
    do_lookup(0, 8'd7);
    wr_en = 1'b0;
    expect_out("bypass_i7", 10'd99, 1'b1, 1'b0);
    do_lookup(0, 8'd7);
    expect_out("after_bypass_i7", 10'd99, 1'b1, 1'b0);
    wr_en = 1'b1; wr_bank = 1; wr_addr = 8'd9; wr_data = 10'd5;
    do_lookup(0, 8'd9);
    wr_en = 1'b0;
    expect_out("xbank_no_bypass", 10'd0, 1'b0, 1'b1);
    do_lookup(1, 8'd9);
    expect_out("xbank_written", 10'd5, 1'b1, 1'b0);

    // Back-to-back branch then deassert: outputs clear.
    bank_sel = 0; addr = 8'd1; branch = 1'b1;
    tick();
    branch = 1'b0;
    expect_out("b2b_hit", 10'd3, 1'b1, 1'b0);
    tick();
    expect_out("b2b_idle", 10'd0, 1'b0, 1'b0);

    // Full-width data stored unmodified; top index of the bank.
    do_write(1, 8'd31, 10'h3FF);
    do_lookup(1, 8'd31);
    expect_out("full_width_i31", 10'h3FF, 1'b1, 1'b0);
    do_lookup(1, 8'd32);
    expect_out("oor_i32", 10'd0, 1'b0, 1'b1);

    // Reset mid-run clears everything.
    reset = 1'b1;
    tick();
    check("rerst_busy", 32'(busy), 32'd1);
    expect_out("rerst", 10'd0, 1'b0, 1'b0);
    reset = 1'b0;
    run_sweep("rerun", 1'b0);
    do_lookup(0, 8'd1);
    expect_out("cleared_b0_i1", 10'd0, 1'b0, 1'b1);
    do_lookup(1, 8'd31);
    expect_out("cleared_b1_i31", 10'd0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_target_table.md
Name: branch_target_table

Overview:
- Programmable, multi-bank branch-target lookup table; successor to the fixed combinational branch LUT.
- Feeds the PC update logic: fetch presents a branch index and receives the absolute jump target one cycle later.
- Each bank holds one program's target set, so programs switch by changing bank_sel instead of rebuilding hardware.
- Entries are loaded at runtime through a write port; after reset, an internal sweep clears all entries before the table accepts traffic.

Parameters:
- D, 10, target (PC) width in bits
- A, 8, lookup/write index width in bits
- DEPTH, 32, entries per bank; legal range 1..2**A
- NBANKS, 2, number of banks (programs); must be >= 1
- BW, $clog2(NBANKS) min 1, bank select width (derived; not overridden)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- bank_sel  in  BW  bank used for lookups
- addr  in  A  lookup index
- branch  in  1  lookup request strobe
- target  out  D  registered lookup result
- target_valid  out  1  target holds a programmed entry for a branch issued last cycle
- miss  out  1  last-cycle branch hit an out-of-range or unprogrammed entry
- wr_en  in  1  write strobe
- wr_bank  in  BW  write bank
- wr_addr  in  A  write index
- wr_data  in  D  write target
- busy  out  1  clear sweep in progress; lookups and writes ignored

Behaviour:
- Storage: NBANKS x DEPTH entries, each D-bit target plus 1 valid bit.
- FSM states: S_CLEAR, S_RUN.
- Reset:
  - FSM goes to S_CLEAR; sweep counter = 0.
  - Outputs: target=0, target_valid=0, miss=0, busy=1.
  - Reset asserted mid-sweep or mid-run restarts the sweep from index 0.
- S_CLEAR:
  - Each cycle writes target=0, valid=0 to one flat entry (bank*DEPTH+index); the counter increments.
  - Sweep takes NBANKS*DEPTH cycles. On the last entry, the next state is S_RUN and busy drops the cycle after the final clear write.
  - busy=1 throughout. wr_en and branch are ignored (no storage change); target=0, target_valid=0, miss=0.
- S_RUN, write:
  - When wr_en=1, wr_bank<NBANKS and wr_addr<DEPTH: entry <= {wr_data, valid=1} at the clock edge.
  - Out-of-range writes are dropped silently.
- S_RUN, lookup (latency 1): branch sampled at edge N produces outputs visible after edge N.
  - branch=1 and entry in range and valid: target=entry, target_valid=1, miss=0.
  - branch=1 and (bank_sel>=NBANKS or addr>=DEPTH or entry not valid): target=0, target_valid=0, miss=1.
  - branch=0: target=0, target_valid=0, miss=0. Registered outputs clear; they do not hold.
- Same-cycle write and lookup to the same bank/index: write-first bypass, so the lookup returns wr_data with target_valid=1.
- Width rules: wr_data is stored unmodified; no truncation or sign extension. The index compare against DEPTH is unsigned.
- No transition S_RUN -> S_CLEAR except via reset.

Decomposition:
- Package bt_pkg:
  - typedef enum logic {S_CLEAR, S_RUN} bt_state_t
  - typedef struct packed {logic vld; logic [D-1:0] tgt;} — parametrised via the module
  - constant BT_RESET_TARGET = '0
- One natural sub-module, bt_bank_mem:
  - Single-bank DEPTH-entry storage.
  - One synchronous write port with valid bit, one registered read port with write-first bypass.
  - Instantiated NBANKS times by generate.
- Top level holds the FSM, sweep counter, range checks and output muxing.

Test Plan:
- Reset release: with defaults, busy=1 for exactly 64 cycles. A branch at cycle 10 of the sweep gives target=0, target_valid=0, miss=0. busy=0 on cycle 65.
- Program and read: write bank0 idx1=3, bank1 idx1=26. Lookup bank_sel=0 addr=1 gives target=3 valid=1 the next cycle; bank_sel=1 addr=1 gives target=26.
- Unprogrammed and out-of-range: after the sweep, branch addr=5 (never written) gives miss=1 target=0. With DEPTH=32, addr=40 gives miss=1. A write to addr=40 leaves all entries unchanged.
- Bypass: same cycle, wr_en bank0 idx7=99 and branch bank_sel=0 addr=7 gives target=99 valid=1 next cycle. Subsequent reads also return 99.
- Branch deassert: back-to-back branch idx1 then branch=0 gives target=3 valid=1, then target=0 valid=0 miss=0.
- Reset mid-run: after programming, assert reset one cycle. busy=1 for 64 cycles, then lookup idx1 gives miss=1, showing all entries were cleared.
